// File: rtl/bin_threshold_ctrl.sv
// rtl/bin_threshold_ctrl.sv - per-frame binarization threshold controller (auto mean / manual)
module bin_threshold_ctrl #(
  parameter int CNT_W      = 22,
  parameter int SUM_W      = 30,
  parameter int DEFAULT_TH = 128,
  parameter int STEP       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       de_in,
  input  logic [7:0] y_in,
  input  logic       mode_auto,
  input  logic [7:0] offset,
  input  logic       key_up,
  input  logic       key_dn,
  output logic [7:0] bin_threshold,
  output logic       th_valid,
  output logic       busy,
  output logic       overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam int IT_W = $clog2(SUM_W);

  logic             vsync_d;
  logic             frame_edge;
  logic [SUM_W-1:0] acc_sum;
  logic [CNT_W-1:0] acc_cnt;
  logic [1:0]       state;

  // Divider: div_q starts as the dividend and shifts quotient bits in from the LSB
  logic [SUM_W-1:0] div_q;
  logic [CNT_W-1:0] div_d;
  logic [CNT_W-1:0] div_rem;
  logic [IT_W-1:0]  it_cnt;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W-1:0] rem_sub;
  logic             rem_ge;

  logic             apply_auto;
  logic [7:0]       off_r;
  logic [7:0]       manual_th;
  logic [7:0]       manual_next;
  logic [8:0]       th_up;
  logic signed [9:0] biased;
  logic [7:0]       auto_th;

  assign frame_edge = vsync_in & ~vsync_d;
  // An edge seen while a divide (or its apply) is pending cannot be serviced
  assign overrun    = frame_edge & busy;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  assign rem_sh  = {div_rem, div_q[SUM_W-1]};
  assign rem_ge  = (rem_sh >= {1'b0, div_d});
  assign rem_sub = rem_sh[CNT_W-1:0] - div_d;

  // Mean never exceeds 255, so only the low quotient byte matters; bias in 10-bit signed
  assign biased  = $signed({2'b00, div_q[7:0]}) + $signed({{2{off_r[7]}}, off_r});
  assign auto_th = biased[9] ? 8'd0 : (biased[8] ? 8'hFF : biased[7:0]);

  assign th_up = {1'b0, manual_th} + 9'(STEP);

  // Next manual threshold from key pulses, saturating at both ends; both keys cancel
  always_comb begin
    manual_next = manual_th;
    if (key_up && !key_dn) begin
      manual_next = th_up[8] ? 8'hFF : th_up[7:0];
    end else if (key_dn && !key_up) begin
      manual_next = (manual_th < 8'(STEP)) ? 8'd0 : manual_th - 8'(STEP);
    end
  end

  // Registered vsync for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsync_d <= 1'b0;
    else     vsync_d <= vsync_in;
  end

  // Luma accumulators; restart at each edge, with an edge-cycle pixel counted in the new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (frame_edge) begin
      acc_sum <= de_in ? SUM_W'(y_in) : '0;
      acc_cnt <= de_in ? CNT_W'(1) : '0;
    end else if (de_in) begin
      acc_sum <= acc_sum + SUM_W'(y_in);
      if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  // Manual threshold tracks key pulses in every mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) manual_th <= 8'(DEFAULT_TH);
    else     manual_th <= manual_next;
  end

  // Frame-boundary FSM: snapshot, divide, then apply the new threshold for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      div_q         <= '0;
      div_d         <= '0;
      div_rem       <= '0;
      it_cnt        <= '0;
      apply_auto    <= 1'b0;
      off_r         <= 8'd0;
      busy          <= 1'b0;
      th_valid      <= 1'b0;
      bin_threshold <= 8'(DEFAULT_TH);
    end else begin
      th_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_edge) begin
            apply_auto <= mode_auto;
            off_r      <= offset;
            if (!mode_auto) begin
              state <= S_APPLY;
            end else if (acc_cnt != '0) begin
              div_q   <= acc_sum;
              div_d   <= acc_cnt;
              div_rem <= '0;
              it_cnt  <= '0;
              busy    <= 1'b1;
              state   <= S_DIV;
            end
          end
        end
        S_DIV: begin
          div_rem <= rem_ge ? rem_sub : rem_sh[CNT_W-1:0];
          div_q   <= {div_q[SUM_W-2:0], rem_ge};
          if (it_cnt == IT_W'(SUM_W - 1)) state <= S_APPLY;
          else                            it_cnt <= it_cnt + IT_W'(1);
        end
        S_APPLY: begin
          bin_threshold <= apply_auto ? auto_th : manual_th;
          th_valid      <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_threshold_ctrl.sv
// tb/tb_bin_threshold_ctrl.sv - self-checking bench for bin_threshold_ctrl
module tb_bin_threshold_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       de_in;
  logic [7:0] y_in;
  logic       mode_auto;
  logic [7:0] offset;
  logic       key_up;
  logic       key_dn;
  logic [7:0] bin_threshold;
  logic       th_valid;
  logic       busy;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_sum = 0;
  int m_cnt = 0;
  int m_manual = 128;
  int m_th = 128;

  bin_threshold_ctrl dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .de_in(de_in), .y_in(y_in),
    .mode_auto(mode_auto), .offset(offset), .key_up(key_up), .key_dn(key_dn),
    .bin_threshold(bin_threshold), .th_valid(th_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int clamp8(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pixels(input int n, input int yfix);
    int y;
    for (int i = 0; i < n; i++) begin
      y = (yfix < 0) ? int'($urandom_range(0, 255)) : yfix;
      de_in = 1'b1;
      y_in  = 8'(y);
      m_sum += y;
      m_cnt++;
      tick();
    end
    de_in = 1'b0;
  endtask

  task automatic key(input bit up, input bit dn);
    key_up = up;
    key_dn = dn;
    tick();
    key_up = 1'b0;
    key_dn = 1'b0;
    tick();
    if (up && !dn) m_manual = clamp8(m_manual + 4);
    else if (dn && !up) m_manual = clamp8(m_manual - 4);
  endtask

  // Frame boundary followed by a 45-cycle observation window
  task automatic frame(input string tag, input bit auto_m, input int off,
                       input bit edge_de, input int edge_y);
    int  exp_th, exp_evt, evt, pulses;
    bit  exp_upd;
    logic busy1;
    exp_th = m_th;
    exp_upd = 1'b0;
    exp_evt = -1;
    if (auto_m) begin
      if (m_cnt > 0) begin
        exp_upd = 1'b1;
        exp_th  = clamp8(m_sum / m_cnt + off);
        exp_evt = 32;
      end
    end else begin
      exp_upd = 1'b1;
      exp_th  = m_manual;
      exp_evt = 2;
    end
    vsync_in  = 1'b1;
    mode_auto = auto_m;
    offset    = 8'(off);
    de_in     = edge_de;
    y_in      = 8'(edge_y);
    m_sum     = edge_de ? edge_y : 0;
    m_cnt     = edge_de ? 1 : 0;
    tick();
    vsync_in = 1'b0;
    de_in    = 1'b0;
    evt = -1;
    pulses = 0;
    busy1 = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 1) busy1 = busy;
      if (th_valid) begin
        pulses++;
        if (evt < 0) evt = k;
      end
      tick();
    end
    chk({tag, "_pulses"}, pulses, exp_upd ? 1 : 0);
    chk({tag, "_latency"}, evt, exp_evt);
    chk({tag, "_th"}, bin_threshold, exp_th);
    if (auto_m && exp_upd) chk({tag, "_busy"}, busy1, 1);
    m_th = exp_th;
  endtask

  initial begin
    int evt, pulses, ov_cnt, exp_r, y;
    rst = 1'b1; vsync_in = 1'b0; de_in = 1'b0; y_in = 8'd0; mode_auto = 1'b1;
    offset = 8'd0; key_up = 1'b0; key_dn = 1'b0;
    tick(); tick();
    chk("rst_th", bin_threshold, 128);
    chk("rst_valid", th_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick();

    // Auto mean of a flat frame
    pixels(16, 100);
    frame("t1", 1'b1, 0, 1'b0, 0);

    // Offset and clamping
    pixels(4, 200);
    frame("t2_hi", 1'b1, 127, 1'b0, 0);
    pixels(5, 50);
    frame("t2_lo", 1'b1, -128, 1'b0, 0);
    pixels(3, 59);
    pixels(3, 61);
    frame("t2_mid", 1'b1, -10, 1'b0, 0);

    // Empty frame: no update
    frame("t3_empty", 1'b1, 0, 1'b0, 0);

    // Second edge while dividing
    pixels(8, -1);
    exp_r = clamp8(m_sum / m_cnt);
    vsync_in = 1'b1; mode_auto = 1'b1; offset = 8'd0; de_in = 1'b0;
    m_sum = 0; m_cnt = 0;
    tick();
    vsync_in = 1'b0;
    evt = -1; pulses = 0; ov_cnt = 0;
    for (int k = 1; k <= 70; k++) begin
      vsync_in = (k == 10);
      if (k == 10) begin
        m_sum = 0;
        m_cnt = 0;
      end
      if ((k >= 3 && k <= 8) || (k >= 12 && k <= 20)) begin
        y = int'($urandom_range(0, 255));
        de_in = 1'b1;
        y_in = 8'(y);
        m_sum += y;
        m_cnt++;
      end else begin
        de_in = 1'b0;
      end
      #1;
      if (overrun) ov_cnt++;
      if (k == 10) chk("t5_overrun_at_edge", overrun, 1);
      if (th_valid) begin
        pulses++;
        if (evt < 0) evt = k;
      end
      tick();
    end
    vsync_in = 1'b0;
    de_in = 1'b0;
    chk("t5_overrun_count", ov_cnt, 1);
    chk("t5_pulses", pulses, 1);
    chk("t5_latency", evt, 32);
    chk("t5_th", bin_threshold, exp_r);
    m_th = exp_r;

    // Randomized frames in both modes
    for (int f = 0; f < 10; f++) begin
      bit am;
      am = $urandom_range(0, 3) != 0;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        key($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      pixels(int'($urandom_range(1, 30)), -1);
      frame($sformatf("rnd%0d", f), am, int'($urandom_range(0, 255)) - 128,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
    end

    // Reset in the middle of a divide
    pixels(4, 77);
    frame("t6_pre", 1'b1, 0, 1'b0, 0);
    pixels(6, 90);
    vsync_in = 1'b1; mode_auto = 1'b1; offset = 8'd0;
    tick();
    vsync_in = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("t6_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_th_reset", bin_threshold, 128);
    chk("t6_busy_reset", busy, 0);
    tick(); tick();
    rst = 1'b0;
    m_sum = 0; m_cnt = 0; m_manual = 128; m_th = 128;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (th_valid) pulses++;
      tick();
    end
    chk("t6_no_valid", pulses, 0);
    chk("t6_th_hold", bin_threshold, 128);

    // Manual threshold from reset value
    for (int j = 0; j < 3; j++) key(1'b1, 1'b0);
    frame("t4_140", 1'b0, 0, 1'b0, 0);
    for (int j = 0; j < 40; j++) key(1'b1, 1'b0);
    frame("t4_sat_hi", 1'b0, 0, 1'b0, 0);
    for (int j = 0; j < 70; j++) key(1'b0, 1'b1);
    frame("t4_sat_lo", 1'b0, 0, 1'b0, 0);
    key(1'b1, 1'b0);
    key(1'b1, 1'b1);
    frame("t4_both", 1'b0, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
